// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, reads one instruction word per
// accepted enable over a req/ack handshake and hands pc/command to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  pc_set,
  input  logic [31:0]           pc_in,
  output logic                  done,
  output logic [31:0]           pc,
  output logic [31:0]           command,
  output logic                  misalign,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state, state_nx;
  logic [31:0]           next_pc, next_pc_nx;
  logic [31:0]           pc_nx, command_nx;
  logic                  done_nx, misalign_nx, imem_req_nx;
  logic [ADDR_WIDTH-1:0] imem_addr_nx;
  logic [31:0]           fetch_pc;
  logic                  accept;

  assign fetch_pc = pc_set ? pc_in : next_pc;
  // An enable landing on the done cycle is dropped so done can never pulse twice in a row.
  assign accept   = (state == IDLE) && enable && !done;

  // NOTE: every signal gets a default before the case; a missing default on any path infers a latch.
  always_comb begin
    state_nx     = state;
    next_pc_nx   = next_pc;
    pc_nx        = pc;
    command_nx   = command;
    misalign_nx  = misalign;
    imem_addr_nx = imem_addr;
    imem_req_nx  = 1'b0;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pc_nx        = fetch_pc;
          imem_addr_nx = fetch_pc[ADDR_WIDTH+1:2];
          if (fetch_pc[1:0] == 2'b00) begin
            imem_req_nx = 1'b1;
            state_nx    = REQ;
          end else begin
            // Misaligned fetch completes at once with a null command, no memory access.
            command_nx  = 32'h0;
            misalign_nx = 1'b1;
            done_nx     = 1'b1;
            next_pc_nx  = fetch_pc + 32'd4;
          end
        end
      end
      REQ, WAIT: begin
        if (imem_ack) begin
          command_nx = imem_rdata;
          done_nx    = 1'b1;
          next_pc_nx = pc + 32'd4;
          state_nx   = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      next_pc   <= RESET_PC;
      pc        <= RESET_PC;
      command   <= 32'h0;
      misalign  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      next_pc   <= next_pc_nx;
      pc        <= pc_nx;
      command   <= command_nx;
      misalign  <= misalign_nx;
      imem_req  <= imem_req_nx;
      imem_addr <= imem_addr_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the expected fetch
// result pushed at enable and popped when done is observed.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ADDR_WIDTH = 15;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  enable = 1'b0;
  logic                  pc_set = 1'b0;
  logic [31:0]           pc_in = 32'h0;
  logic                  imem_ack = 1'b0;
  logic [31:0]           imem_rdata = 32'h0;
  logic                  done, misalign, imem_req;
  logic [31:0]           pc, command;
  logic [ADDR_WIDTH-1:0] imem_addr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cmd;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_next_pc = RESET_PC;
  logic [31:0] model_pc      = RESET_PC;
  logic [31:0] model_cmd     = 32'h0;
  logic        model_mis     = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .pc_set     (pc_set),
    .pc_in      (pc_in),
    .done       (done),
    .pc         (pc),
    .command    (command),
    .misalign   (misalign),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Quiet cycles: outputs must hold; optional noise on ack and pc_set must be ignored.
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      imem_ack   = noise;
      imem_rdata = $urandom;
      pc_set     = noise;
      pc_in      = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
      pc_set   = 1'b0;
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_req", 32'(imem_req), 32'h0);
      chk("idle_pc", pc, model_pc);
      chk("idle_cmd", command, model_cmd);
    end
  endtask

  // One fetch starting at a negedge; memory acks 'delay' cycles after the req cycle.
  task automatic fetch(input bit set, input logic [31:0] target, input int delay,
                       input logic [31:0] rdata, input bit extra);
    logic [31:0] fp;
    bit          aligned;
    exp_t        e;
    int          cyc;
    fp      = set ? target : model_next_pc;
    aligned = (fp[1:0] == 2'b00);
    if (!aligned) model_mis = 1'b1;
    e.pc  = fp;
    e.cmd = aligned ? rdata : 32'h0;
    e.mis = model_mis;
    e.lat = aligned ? 2 + delay : 1;
    sb.push_back(e);
    model_next_pc = fp + 32'd4;
    model_pc      = e.pc;
    model_cmd     = e.cmd;

    enable = 1'b1;
    pc_set = set;
    pc_in  = target;
    @(negedge clk);
    enable = 1'b0;
    pc_set = 1'b0;
    pc_in  = $urandom;
    cyc    = 1;
    chk("pc_t1", pc, fp);
    chk("req_t1", 32'(imem_req), 32'(aligned));
    if (aligned) chk("addr_t1", 32'(imem_addr), 32'(fp[ADDR_WIDTH+1:2]));
    while (!done && cyc < 40) begin
      imem_ack   = aligned && (cyc == 1 + delay);
      imem_rdata = imem_ack ? rdata : $urandom;
      enable     = extra && (cyc == 2);
      @(negedge clk);
      cyc++;
      imem_ack = 1'b0;
      enable   = 1'b0;
      if (!done) begin
        chk("req_low", 32'(imem_req), 32'h0);
        chk("addr_hold", 32'(imem_addr), 32'(fp[ADDR_WIDTH+1:2]));
      end
    end

    e = sb.pop_front();
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("done_pc", pc, e.pc);
    chk("command", command, e.cmd);
    chk("misalign", 32'(misalign), 32'(e.mis));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'h0);
    chk("pc_hold", pc, e.pc);
    chk("cmd_hold", command, e.cmd);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    chk("rst_cmd", command, 32'h0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Zero-wait fetch, then sequential fetch.
    fetch(1'b0, 32'h0, 0, 32'h2002_0005, 1'b0);
    idle(1, 1'b0);
    fetch(1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    idle(1, 1'b0);

    // Three wait cycles with a stray enable in WAIT; no second fetch may follow.
    fetch(1'b0, 32'h0, 3, 32'h1234_5678, 1'b1);
    idle(3, 1'b0);

    // Aligned redirect then sequential.
    fetch(1'b1, 32'h0000_0100, 0, 32'h0800_0010, 1'b0);
    idle(1, 1'b0);
    fetch(1'b0, 32'h0, 2, 32'hA5A5_0001, 1'b0);
    idle(1, 1'b0);

    // Misaligned redirect; the sequential follow-up 0x106 is misaligned too.
    fetch(1'b1, 32'h0000_0102, 0, 32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b0);
    fetch(1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b0);

    // Wrap from the top of the address space; stray ack/pc_set in IDLE ignored.
    fetch(1'b1, 32'hFFFF_FFFC, 0, 32'h0BAD_CAFE, 1'b0);
    idle(2, 1'b1);
    fetch(1'b0, 32'h0, 0, 32'h0000_1111, 1'b0);
    idle(1, 1'b0);

    // Reset while waiting for memory; the late ack must be ignored.
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn       = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("rw_done", 32'(done), 32'h0);
    chk("rw_pc", pc, RESET_PC);
    chk("rw_cmd", command, 32'h0);
    chk("rw_req", 32'(imem_req), 32'h0);
    chk("rw_mis", 32'(misalign), 32'h0);
    chk("rw_addr", 32'(imem_addr), 32'h0);
    model_next_pc = RESET_PC;
    model_pc      = RESET_PC;
    model_cmd     = 32'h0;
    model_mis     = 1'b0;
    idle(2, 1'b0);
    fetch(1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0);
    idle(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Holds the architectural fetch PC and issues one word read per enable to instruction memory over a req/ack handshake.
- Presents the fetched pc and command to decode with a one-cycle done pulse; decode's enable is driven from that pulse.
- Accepts a redirect PC from the execute stage for jumps and branches; otherwise advances sequentially by 4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
ADDR_WIDTH, 15, word-address width of instruction memory

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
enable  input  1  start one fetch (single-cycle pulse from controller)
pc_set  input  1  qualifies enable: fetch from pc_in instead of sequential PC
pc_in  input  32  redirect target from execute
done  output  1  one-cycle pulse: pc/command valid
pc  output  32  byte address of the instruction in command
command  output  32  fetched instruction word
misalign  output  1  sticky: a fetch PC had pc[1:0]!=0
imem_req  output  1  memory read request
imem_addr  output  ADDR_WIDTH  word address = fetch_pc[ADDR_WIDTH+1:2]
imem_rdata  input  32  memory read data
imem_ack  input  1  read data valid this cycle

Behaviour:
- Reset (clk edge with rstn=0):
  - Outputs: done=0, imem_req=0, misalign=0, command=0, pc=RESET_PC, imem_addr=0.
  - Internal next_pc=RESET_PC; state=IDLE.
  - Reset mid-fetch aborts immediately; a later imem_ack is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - An enable is accepted only in IDLE.
  - fetch_pc = pc_set ? pc_in : next_pc.
  - On the accept edge: pc<=fetch_pc; imem_addr<=fetch_pc[ADDR_WIDTH+1:2].
  - If fetch_pc[1:0]==0: imem_req<=1; go to REQ.
  - Else (misaligned): no memory request; command<=32'h0; misalign<=1; done<=1 on the next edge; next_pc<=fetch_pc+4; stay IDLE.
- REQ:
  - imem_req is high for exactly this one cycle, then deasserted.
  - If imem_ack=1 in this cycle, complete (see below); otherwise go to WAIT.
- WAIT:
  - imem_req=0; imem_addr held.
  - Remain in WAIT until imem_ack=1, then complete. No timeout.
- Complete (edge on which ack is sampled in REQ or WAIT):
  - command<=imem_rdata; done<=1 for one cycle; next_pc<=pc+4; return to IDLE.
- Latency:
  - enable at edge t; imem_req high in cycle t+1.
  - Zero-wait ack in cycle t+1 gives done and command valid in cycle t+2.
  - Each extra wait cycle adds one.
- Stability:
  - pc changes only on an accepted enable.
  - command changes only on completion, a misaligned fetch, or reset.
  - Both hold until the next accepted enable, because decode samples them on its enable cycle and the cycle after.
- Ignored inputs:
  - enable in REQ or WAIT is ignored (not queued).
  - pc_set without enable has no effect.
  - imem_ack in IDLE is ignored.
- Arithmetic: next_pc = pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- misalign is cleared only by reset.
- done is never high on two consecutive cycles.

Test Plan:
1. Reset with RESET_PC=0, then enable, memory acks in the req cycle with rdata=32'h2002_0005 -> imem_addr=0, done at t+2, pc=0, command=32'h2002_0005; a second enable gives pc=4, imem_addr=1.
2. Enable, ack delayed 3 cycles; an extra enable is pulsed in WAIT -> imem_req high exactly 1 cycle; done at t+5; the extra enable produces no second fetch.
3. enable with pc_set=1, pc_in=32'h0000_0100, rdata=32'h0800_0010 -> imem_addr=64, pc=32'h100, command=32'h0800_0010; a following plain enable fetches pc=32'h104.
4. enable with pc_set=1, pc_in=32'h0000_0102 -> no imem_req; done one cycle later; command=0; misalign=1; the next plain enable fetches 32'h106 and misalign stays 1.
5. Redirect to pc_in=32'hFFFF_FFFC, ack, then a plain enable -> second fetch pc=0, imem_addr=0.
6. Assert rstn=0 while in WAIT, then ack arrives after reset -> done stays 0, pc=RESET_PC, command=0, state IDLE; the next enable fetches RESET_PC normally.
